// File: rtl/exc_pkg.sv
// Shared definitions for the precise-exception commit unit: cause-bit indices, ExcCodes, vectors, FSM states.
// Define EXC_TLB_EN to decode the TLB causes and use the refill vector; otherwise those causes are masked off.
package exc_pkg;

  localparam logic [3:0] C_INT         = 4'd0;
  localparam logic [3:0] C_I_REFILL    = 4'd1;
  localparam logic [3:0] C_I_INVALID   = 4'd2;
  localparam logic [3:0] C_I_ADEL      = 4'd3;
  localparam logic [3:0] C_RI          = 4'd4;
  localparam logic [3:0] C_OV          = 4'd5;
  localparam logic [3:0] C_SYS         = 4'd6;
  localparam logic [3:0] C_BP          = 4'd7;
  localparam logic [3:0] C_ERET        = 4'd8;
  localparam logic [3:0] C_D_REFILL_L  = 4'd9;
  localparam logic [3:0] C_D_INVALID_L = 4'd10;
  localparam logic [3:0] C_D_REFILL_S  = 4'd11;
  localparam logic [3:0] C_D_INVALID_S = 4'd12;
  localparam logic [3:0] C_D_ADEL      = 4'd13;
  localparam logic [3:0] C_D_ADES      = 4'd14;
  localparam logic [3:0] C_MOD         = 4'd15;

  localparam logic [4:0] EC_INT  = 5'h00;
  localparam logic [4:0] EC_MOD  = 5'h01;
  localparam logic [4:0] EC_TLBL = 5'h02;
  localparam logic [4:0] EC_TLBS = 5'h03;
  localparam logic [4:0] EC_ADEL = 5'h04;
  localparam logic [4:0] EC_ADES = 5'h05;
  localparam logic [4:0] EC_SYS  = 5'h08;
  localparam logic [4:0] EC_BP   = 5'h09;
  localparam logic [4:0] EC_RI   = 5'h0A;
  localparam logic [4:0] EC_OV   = 5'h0C;

  localparam logic [31:0] VEC_REFILL_OFS  = 32'h0000_0200;
  localparam logic [31:0] VEC_GENERAL_OFS = 32'h0000_0380;

  localparam logic [1:0] BV_NONE = 2'd0;
  localparam logic [1:0] BV_PC   = 2'd1;
  localparam logic [1:0] BV_ADDR = 2'd2;

  // i_refill, i_invalid, d_refill_l/s, d_invalid_l/s, mod
  localparam logic [15:0] TLB_CAUSES = 16'h9E06;
`ifdef EXC_TLB_EN
  localparam logic [15:0] CAUSE_MASK = 16'hFFFF;
`else
  localparam logic [15:0] CAUSE_MASK = ~TLB_CAUSES;
`endif

  typedef enum logic {S_IDLE, S_BUSY} state_e;

endpackage

// File: rtl/exc_lane_decode.sv
// Per-lane cause decode: picks the highest-priority (lowest-index) enabled cause bit
// and reports its ExcCode, vector class and which address feeds BadVAddr/EntryHi.
module exc_lane_decode
  import exc_pkg::*;
(
  input  logic        valid,
  input  logic        refetch,
  input  logic [15:0] exc,
  output logic        has_event,
  output logic [4:0]  exccode,
  output logic        is_eret,
  output logic        is_refill,
  output logic [1:0]  badvaddr_src,
  output logic        entryhi_we
);

  logic [15:0] exc_m;
  logic [3:0]  sel;

  always_comb begin
    exc_m = exc & CAUSE_MASK;
    sel   = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (exc_m[i]) sel = 4'(i);
    end
    has_event    = valid & (refetch | (|exc_m));
    exccode      = EC_INT;
    is_eret      = 1'b0;
    is_refill    = 1'b0;
    badvaddr_src = BV_NONE;
    entryhi_we   = 1'b0;
    case (sel)
      C_I_REFILL:    begin exccode = EC_TLBL; is_refill = 1'b1; badvaddr_src = BV_PC;   entryhi_we = 1'b1; end
      C_I_INVALID:   begin exccode = EC_TLBL; badvaddr_src = BV_PC;   entryhi_we = 1'b1; end
      C_I_ADEL:      begin exccode = EC_ADEL; badvaddr_src = BV_PC;   end
      C_RI:          exccode = EC_RI;
      C_OV:          exccode = EC_OV;
      C_SYS:         exccode = EC_SYS;
      C_BP:          exccode = EC_BP;
      C_ERET:        is_eret = 1'b1;
      C_D_REFILL_L:  begin exccode = EC_TLBL; is_refill = 1'b1; badvaddr_src = BV_ADDR; entryhi_we = 1'b1; end
      C_D_INVALID_L: begin exccode = EC_TLBL; badvaddr_src = BV_ADDR; entryhi_we = 1'b1; end
      C_D_REFILL_S:  begin exccode = EC_TLBS; is_refill = 1'b1; badvaddr_src = BV_ADDR; entryhi_we = 1'b1; end
      C_D_INVALID_S: begin exccode = EC_TLBS; badvaddr_src = BV_ADDR; entryhi_we = 1'b1; end
      C_D_ADEL:      begin exccode = EC_ADEL; badvaddr_src = BV_ADDR; end
      C_D_ADES:      begin exccode = EC_ADES; badvaddr_src = BV_ADDR; end
      C_MOD:         begin exccode = EC_MOD;  badvaddr_src = BV_ADDR; entryhi_we = 1'b1; end
      default:       ;
    endcase
  end

endmodule

// File: rtl/exc_commit_unit.sv
// Precise-exception commit unit: oldest excepting/refetching lane wins, flushes the pipe and
// holds a registered redirect until fetch accepts it. TLB causes decoded only with EXC_TLB_EN.
module exc_commit_unit
  import exc_pkg::*;
#(
  parameter int          LANES    = 2,
  parameter logic [31:0] EXC_BASE = 32'hBFC0_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES-1:0]      lane_valid,
  input  logic [LANES-1:0]      lane_refetch,
  input  logic [LANES*32-1:0]   lane_pc,
  input  logic [LANES*32-1:0]   lane_badvaddr,
  input  logic [LANES-1:0]      lane_bd,
  input  logic [LANES*16-1:0]   lane_exc,
  input  logic [31:0]           cp0_epc,
  input  logic                  cp0_exl,
  output logic                  flush,
  output logic [LANES-1:0]      kill_mask,
  output logic                  redirect_valid,
  input  logic                  redirect_ready,
  output logic [31:0]           redirect_pc,
  output logic                  cp0_we,
  output logic [4:0]            cp0_exccode,
  output logic                  cp0_bd,
  output logic                  cp0_epc_we,
  output logic [31:0]           cp0_epc_o,
  output logic                  cp0_badvaddr_we,
  output logic [31:0]           cp0_badvaddr,
  output logic                  cp0_entryhi_we,
  output logic [18:0]           cp0_entryhi_vpn2,
  output logic                  cp0_cls_exl
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0]      has_evt, is_eret, is_refill, ehi_we;
  logic [LANES-1:0][4:0] code;
  logic [LANES-1:0][1:0] bv_src;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    exc_lane_decode u_dec (
      .valid        (lane_valid[g]),
      .refetch      (lane_refetch[g]),
      .exc          (lane_exc[g*16 +: 16]),
      .has_event    (has_evt[g]),
      .exccode      (code[g]),
      .is_eret      (is_eret[g]),
      .is_refill    (is_refill[g]),
      .badvaddr_src (bv_src[g]),
      .entryhi_we   (ehi_we[g])
    );
  end

  state_e        state_q, state_d;
  logic [IW-1:0] win_idx;
  logic          any_evt, capture;
  logic [31:0]   w_pc, w_bv;

  always_comb begin
    win_idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (has_evt[i]) win_idx = IW'(i);
    end
    // Reset also masks detection so flush drops the moment rst rises.
    any_evt = (|has_evt) & ~rst;
    capture = (state_q == S_IDLE) & any_evt;
    w_pc    = lane_pc[int'(win_idx)*32 +: 32];
    w_bv    = lane_badvaddr[int'(win_idx)*32 +: 32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_evt) state_d = S_BUSY;
      S_BUSY:  if (redirect_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    flush          = 1'b0;
    kill_mask      = '0;
    redirect_valid = 1'b0;
    if (state_q == S_BUSY) begin
      flush          = 1'b1;
      kill_mask      = '1;
      redirect_valid = 1'b1;
    end else if (any_evt) begin
      flush = 1'b1;
      for (int i = 0; i < LANES; i++) kill_mask[i] = (i >= int'(win_idx));
    end
  end

  logic [31:0] redirect_pc_q, redirect_pc_d, epc_o_q, epc_o_d, bv_q, bv_d;
  logic [4:0]  exccode_q, exccode_d;
  logic        we_q, we_d, bd_q, bd_d, epc_we_q, epc_we_d, bv_we_q, bv_we_d;
  logic        ehi_we_q, ehi_we_d, cls_q, cls_d;
  logic        w_exc;

  always_comb begin
    w_exc         = ~lane_refetch[win_idx] & ~is_eret[win_idx];
    redirect_pc_d = redirect_pc_q;
    epc_o_d       = epc_o_q;
    bv_d          = bv_q;
    exccode_d     = exccode_q;
    bd_d          = bd_q;
    we_d          = 1'b0;
    epc_we_d      = 1'b0;
    bv_we_d       = 1'b0;
    ehi_we_d      = 1'b0;
    cls_d         = 1'b0;
    if (capture) begin
      if (lane_refetch[win_idx])                   redirect_pc_d = w_pc;
      else if (is_eret[win_idx])                   redirect_pc_d = cp0_epc;
      else if (is_refill[win_idx] && !cp0_exl)     redirect_pc_d = EXC_BASE + VEC_REFILL_OFS;
      else                                         redirect_pc_d = EXC_BASE + VEC_GENERAL_OFS;
      cls_d     = ~lane_refetch[win_idx] & is_eret[win_idx];
      we_d      = w_exc;
      exccode_d = w_exc ? code[win_idx] : EC_INT;
      // Nested exception: EPC and BD keep describing the original fault.
      epc_we_d  = w_exc & ~cp0_exl;
      bd_d      = w_exc & ~cp0_exl & lane_bd[win_idx];
      epc_o_d   = lane_bd[win_idx] ? w_pc - 32'd4 : w_pc;
      bv_we_d   = w_exc & (bv_src[win_idx] != BV_NONE);
      bv_d      = (bv_src[win_idx] == BV_PC) ? w_pc : w_bv;
      ehi_we_d  = w_exc & ehi_we[win_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pc_q <= EXC_BASE + VEC_GENERAL_OFS;
      epc_o_q       <= '0;
      bv_q          <= '0;
      exccode_q     <= '0;
      bd_q          <= 1'b0;
      we_q          <= 1'b0;
      epc_we_q      <= 1'b0;
      bv_we_q       <= 1'b0;
      ehi_we_q      <= 1'b0;
      cls_q         <= 1'b0;
    end else begin
      redirect_pc_q <= redirect_pc_d;
      epc_o_q       <= epc_o_d;
      bv_q          <= bv_d;
      exccode_q     <= exccode_d;
      bd_q          <= bd_d;
      we_q          <= we_d;
      epc_we_q      <= epc_we_d;
      bv_we_q       <= bv_we_d;
      ehi_we_q      <= ehi_we_d;
      cls_q         <= cls_d;
    end
  end

  assign redirect_pc      = redirect_pc_q;
  assign cp0_we           = we_q;
  assign cp0_exccode      = exccode_q;
  assign cp0_bd           = bd_q;
  assign cp0_epc_we       = epc_we_q;
  assign cp0_epc_o        = epc_o_q;
  assign cp0_badvaddr_we  = bv_we_q;
  assign cp0_badvaddr     = bv_q;
  assign cp0_entryhi_we   = ehi_we_q;
  assign cp0_entryhi_vpn2 = bv_q[31:13];
  assign cp0_cls_exl      = cls_q;

endmodule

// File: tb/tb_exc_commit_unit.sv
// Directed bench for exc_commit_unit (LANES=2); TLB expectations follow EXC_TLB_EN.
module tb_exc_commit_unit;

  logic        clk, rst;
  logic [1:0]  lane_valid, lane_refetch, lane_bd;
  logic [63:0] lane_pc, lane_badvaddr;
  logic [31:0] lane_exc;
  logic [31:0] cp0_epc;
  logic        cp0_exl;
  logic        flush, redirect_valid, redirect_ready;
  logic [1:0]  kill_mask;
  logic [31:0] redirect_pc, cp0_epc_o, cp0_badvaddr;
  logic        cp0_we, cp0_bd, cp0_epc_we, cp0_badvaddr_we, cp0_entryhi_we, cp0_cls_exl;
  logic [4:0]  cp0_exccode;
  logic [18:0] cp0_entryhi_vpn2;

  int total = 0;
  int bad   = 0;

  exc_commit_unit #(.LANES(2), .EXC_BASE(32'hBFC0_0000)) dut (
    .clk(clk), .rst(rst),
    .lane_valid(lane_valid), .lane_refetch(lane_refetch), .lane_pc(lane_pc),
    .lane_badvaddr(lane_badvaddr), .lane_bd(lane_bd), .lane_exc(lane_exc),
    .cp0_epc(cp0_epc), .cp0_exl(cp0_exl),
    .flush(flush), .kill_mask(kill_mask),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .cp0_we(cp0_we), .cp0_exccode(cp0_exccode), .cp0_bd(cp0_bd),
    .cp0_epc_we(cp0_epc_we), .cp0_epc_o(cp0_epc_o),
    .cp0_badvaddr_we(cp0_badvaddr_we), .cp0_badvaddr(cp0_badvaddr),
    .cp0_entryhi_we(cp0_entryhi_we), .cp0_entryhi_vpn2(cp0_entryhi_vpn2),
    .cp0_cls_exl(cp0_cls_exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_lanes();
    lane_valid    = 2'b00;
    lane_refetch  = 2'b00;
    lane_bd       = 2'b00;
    lane_pc       = '0;
    lane_badvaddr = '0;
    lane_exc      = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_lanes(); cp0_epc = '0; cp0_exl = 1'b0; redirect_ready = 1'b1;
    #12;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%h exp=0", flush); end
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%h exp=0", redirect_valid); end
    total++; if (redirect_pc !== 32'hBFC0_0380) begin bad++; $display("FAIL reset_rpc got=%h exp=bfc00380", redirect_pc); end
    total++; if ({cp0_we, cp0_epc_we, cp0_cls_exl, cp0_entryhi_we} !== 4'b0) begin bad++; $display("FAIL reset_strobes got=%b exp=0000", {cp0_we, cp0_epc_we, cp0_cls_exl, cp0_entryhi_we}); end
    total++; if (kill_mask !== 2'b00) begin bad++; $display("FAIL reset_kill got=%b exp=00", kill_mask); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ov_lane1();
    lane_valid = 2'b11; lane_exc = {16'h0020, 16'h0000}; lane_pc = {32'h8000_1004, 32'h8000_1000};
    #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL ov_flush got=%h exp=1", flush); end
    total++; if (kill_mask !== 2'b10) begin bad++; $display("FAIL ov_kill got=%b exp=10", kill_mask); end
    tick(); idle_lanes();
    total++; if (cp0_we !== 1'b1) begin bad++; $display("FAIL ov_we got=%h exp=1", cp0_we); end
    total++; if (cp0_exccode !== 5'h0C) begin bad++; $display("FAIL ov_code got=%h exp=0c", cp0_exccode); end
    total++; if (cp0_epc_we !== 1'b1 || cp0_epc_o !== 32'h8000_1004) begin bad++; $display("FAIL ov_epc got=%h/%h exp=1/80001004", cp0_epc_we, cp0_epc_o); end
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_0380) begin bad++; $display("FAIL ov_redirect got=%h/%h exp=1/bfc00380", redirect_valid, redirect_pc); end
    total++; if (kill_mask !== 2'b11 || cp0_badvaddr_we !== 1'b0) begin bad++; $display("FAIL ov_busy got=%b/%h exp=11/0", kill_mask, cp0_badvaddr_we); end
    tick();
    total++; if (cp0_we !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL ov_after got=%h%h%h exp=000", cp0_we, redirect_valid, flush); end
  endtask

  task automatic test_lane0_wins();
    lane_valid = 2'b11; lane_exc = {16'h0010, 16'h0040}; lane_pc = {32'h0000_0004, 32'h0000_0000}; lane_bd = 2'b01;
    #1;
    total++; if (kill_mask !== 2'b11) begin bad++; $display("FAIL win_kill got=%b exp=11", kill_mask); end
    tick(); idle_lanes();
    total++; if (cp0_exccode !== 5'h08) begin bad++; $display("FAIL win_code got=%h exp=08", cp0_exccode); end
    total++; if (cp0_epc_o !== 32'hFFFF_FFFC || cp0_bd !== 1'b1) begin bad++; $display("FAIL win_epc_wrap got=%h/%h exp=fffffffc/1", cp0_epc_o, cp0_bd); end
    tick();
  endtask

  task automatic test_nested_exl();
    cp0_exl = 1'b1;
    lane_valid = 2'b01; lane_exc = {16'h0, 16'h0020}; lane_pc = {32'h0, 32'h8000_2000}; lane_bd = 2'b01;
    tick(); idle_lanes();
    total++; if (cp0_we !== 1'b1 || cp0_epc_we !== 1'b0 || cp0_bd !== 1'b0) begin bad++; $display("FAIL exl_cp0 got=%h%h%h exp=100", cp0_we, cp0_epc_we, cp0_bd); end
    total++; if (redirect_pc !== 32'hBFC0_0380) begin bad++; $display("FAIL exl_rpc got=%h exp=bfc00380", redirect_pc); end
    cp0_exl = 1'b0;
    tick();
  endtask

  task automatic test_d_adel();
    lane_valid = 2'b01; lane_exc = {16'h0, 16'h2000}; lane_pc = {32'h0, 32'h8000_3000}; lane_badvaddr = {32'h0, 32'h1234_5679};
    tick(); idle_lanes();
    total++; if (cp0_exccode !== 5'h04 || cp0_badvaddr_we !== 1'b1 || cp0_badvaddr !== 32'h1234_5679) begin bad++; $display("FAIL dadel got=%h/%h/%h exp=04/1/12345679", cp0_exccode, cp0_badvaddr_we, cp0_badvaddr); end
    total++; if (cp0_entryhi_we !== 1'b0) begin bad++; $display("FAIL dadel_ehi got=%h exp=0", cp0_entryhi_we); end
    tick();
  endtask

  task automatic test_tlb();
    lane_valid = 2'b01; lane_exc = {16'h0, 16'h0800}; lane_pc = {32'h0, 32'h8000_4000}; lane_badvaddr = {32'h0, 32'h0040_2ABC};
`ifdef EXC_TLB_EN
    tick(); idle_lanes();
    total++; if (redirect_pc !== 32'hBFC0_0200 || cp0_exccode !== 5'h03) begin bad++; $display("FAIL tlb_refill got=%h/%h exp=bfc00200/03", redirect_pc, cp0_exccode); end
    total++; if (cp0_entryhi_we !== 1'b1 || cp0_entryhi_vpn2 !== 19'h00201 || cp0_badvaddr !== 32'h0040_2ABC) begin bad++; $display("FAIL tlb_ehi got=%h/%h/%h exp=1/00201/00402abc", cp0_entryhi_we, cp0_entryhi_vpn2, cp0_badvaddr); end
    tick();
    cp0_exl = 1'b1;
    lane_valid = 2'b01; lane_exc = {16'h0, 16'h0800}; lane_badvaddr = {32'h0, 32'h0040_2ABC};
    tick(); idle_lanes();
    total++; if (redirect_pc !== 32'hBFC0_0380 || cp0_epc_we !== 1'b0) begin bad++; $display("FAIL tlb_exl got=%h/%h exp=bfc00380/0", redirect_pc, cp0_epc_we); end
    cp0_exl = 1'b0;
    tick();
`else
    #1;
    total++; if (flush !== 1'b0 || kill_mask !== 2'b00) begin bad++; $display("FAIL tlb_masked got=%h/%b exp=0/00", flush, kill_mask); end
    lane_valid = 2'b11; lane_exc = {16'h8000, 16'h8000};
    #1;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL mod_masked got=%h exp=0", flush); end
    tick();
    total++; if (cp0_we !== 1'b0 || redirect_valid !== 1'b0 || cp0_entryhi_we !== 1'b0) begin bad++; $display("FAIL mod_noevt got=%h%h%h exp=000", cp0_we, redirect_valid, cp0_entryhi_we); end
    idle_lanes();
`endif
  endtask

  task automatic test_eret();
    cp0_epc = 32'h8000_0200;
    lane_valid = 2'b01; lane_exc = {16'h0, 16'h0100}; lane_pc = {32'h0, 32'h8000_5000};
    tick(); idle_lanes();
    total++; if (cp0_cls_exl !== 1'b1 || cp0_we !== 1'b0) begin bad++; $display("FAIL eret_cp0 got=%h/%h exp=1/0", cp0_cls_exl, cp0_we); end
    total++; if (redirect_pc !== 32'h8000_0200) begin bad++; $display("FAIL eret_rpc got=%h exp=80000200", redirect_pc); end
    tick();
    total++; if (cp0_cls_exl !== 1'b0) begin bad++; $display("FAIL eret_pulse got=%h exp=0", cp0_cls_exl); end
  endtask

  task automatic test_refetch_stall();
    redirect_ready = 1'b0;
    lane_valid = 2'b01; lane_refetch = 2'b01; lane_exc = {16'h0, 16'h0001}; lane_pc = {32'h0, 32'h8000_0040};
    #1;
    total++; if (flush !== 1'b1 || kill_mask !== 2'b11) begin bad++; $display("FAIL rf_detect got=%h/%b exp=1/11", flush, kill_mask); end
    tick();
    lane_valid = 2'b10; lane_refetch = 2'b00; lane_exc = {16'h0020, 16'h0}; lane_pc = {32'h9000_0000, 32'h0};
    total++; if (cp0_we !== 1'b0 || cp0_epc_we !== 1'b0) begin bad++; $display("FAIL rf_nocp0 got=%h/%h exp=0/0", cp0_we, cp0_epc_we); end
    for (int k = 0; k < 3; k++) begin
      total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0040 || kill_mask !== 2'b11) begin bad++; $display("FAIL rf_hold%0d got=%h/%h/%b exp=1/80000040/11", k, redirect_valid, redirect_pc, kill_mask); end
      tick();
    end
    total++; if (cp0_we !== 1'b0 || redirect_pc !== 32'h8000_0040) begin bad++; $display("FAIL rf_ignored got=%h/%h exp=0/80000040", cp0_we, redirect_pc); end
    idle_lanes();
    redirect_ready = 1'b1;
    tick();
    total++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL rf_idle got=%h/%h exp=0/0", redirect_valid, flush); end
  endtask

  task automatic test_back_to_back();
    lane_valid = 2'b01; lane_exc = {16'h0, 16'h0020}; lane_pc = {32'h0, 32'h0000_0100};
    tick();
    lane_valid = 2'b11; lane_refetch = 2'b10; lane_exc = '0; lane_pc = {32'h0000_0200, 32'h0000_0104};
    tick();
    total++; if (flush !== 1'b1 || kill_mask !== 2'b10 || redirect_valid !== 1'b0) begin bad++; $display("FAIL b2b_detect got=%h/%b/%h exp=1/10/0", flush, kill_mask, redirect_valid); end
    tick(); idle_lanes();
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0200 || cp0_we !== 1'b0) begin bad++; $display("FAIL b2b_second got=%h/%h/%h exp=1/00000200/0", redirect_valid, redirect_pc, cp0_we); end
    tick();
  endtask

  task automatic test_reset_busy();
    redirect_ready = 1'b0;
    lane_valid = 2'b01; lane_exc = {16'h0, 16'h0020}; lane_pc = {32'h0, 32'h8000_6000};
    tick();
    total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL rstb_busy got=%h exp=1", redirect_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'hBFC0_0380) begin bad++; $display("FAIL rstb_drop got=%h/%h/%h exp=0/0/bfc00380", flush, redirect_valid, redirect_pc); end
    idle_lanes();
    @(negedge clk);
    rst = 1'b0; redirect_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_ov_lane1();
    test_lane0_wins();
    test_nested_exl();
    test_d_adel();
    test_tlb();
    test_eret();
    test_refetch_stall();
    test_back_to_back();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
